// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard controller for the 5-stage in-order pipeline. It resolves
// three hazards: taken-branch redirects from EX, multi-cycle MUL/DIV
// occupancy of EX, and load-use data hazards. That list is also the
// priority order, highest first. The control outputs are combinational
// from the current inputs and FSM state, so the stage registers react in
// the same cycle.
//
// Optional feature: define PERF_CNT_EN to build the saturating stall and
// flush performance counters. Without it, stall_cnt and flush_cnt are
// tied to zero.
//
// Parameters:
//   MD_LAT  total cycles a MUL/DIV op occupies EX (>=1)
//   CNT_W   performance counter width
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   rs1_D, rs2_D                  ID source registers
//   rs1_used_D, rs2_used_D        ID source actually read
//   rd_E, mem_read_E              EX destination / EX is a load
//   md_op_E, br_taken_E           EX is MUL/DIV / EX redirects PC
//   pc_en                         PC update enable
//   if_id_en, if_id_flush         IF/ID enable / flush
//   id_ex_en, id_ex_flush         ID/EX enable / flush (bubble)
//   ex_mem_bubble                 load NOP into EX/MEM
//   md_busy                       MUL/DIV FSM in BUSY
//   stall_cnt, flush_cnt          performance counters
module pipeline_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic [4:0]       rd_E,
  input  logic             mem_read_E,
  input  logic             md_op_E,
  input  logic             br_taken_E,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // cnt holds the remaining stall cycles after the first one, so it never
  // needs to reach MD_LAT-1.
  localparam int CW = (MD_LAT <= 2) ? 1 : $clog2(MD_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'((MD_LAT >= 2) ? (MD_LAT - 2) : 0);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Single-cycle MUL/DIV never needs the FSM.
  localparam logic MD_MULTI = (MD_LAT >= 2) ? 1'b1 : 1'b0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state_r;
  logic [0:0]    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          load_use_s;
  logic          md_stall_s;

  // Hazard detection from the current ID/EX contents and FSM state.
  always_comb begin
    load_use_s = mem_read_E && (rd_E != 5'd0) &&
                 ((rs1_used_D && (rs1_D == rd_E)) ||
                  (rs2_used_D && (rs2_D == rd_E)));
    md_stall_s = MD_MULTI &&
                 (((state_r == ST_IDLE) && md_op_E) ||
                  ((state_r == ST_BUSY) && (cnt_r != CNT_ZERO)));
  end

  // Prioritised stage-register control; everything is held off in reset.
  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    if (!rst_n) begin
      pc_en         = 1'b0;
    end else if (br_taken_E) begin
      // The ID instruction is flushed, so a load-use match is irrelevant.
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (md_stall_s) begin
      // Freeze IF/ID/EX and push NOPs into MEM. Any load-use match is
      // masked here and re-checked after release.
      ex_mem_bubble = 1'b1;
    end else if (load_use_s) begin
      id_ex_en      = 1'b1;
      id_ex_flush   = 1'b1;
    end else begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
    end
  end

  assign md_busy = (state_r == ST_BUSY);

  // MUL/DIV occupancy FSM next state; a branch always aborts to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (br_taken_E) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (MD_MULTI && md_op_E) begin
            state_nxt_s = ST_BUSY;
            cnt_nxt_s   = CNT_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        ST_BUSY: begin
          // cnt==0 is the release cycle: md_op_E is not looked at here.
          if (cnt_r != CNT_ZERO) begin
            state_nxt_s = ST_BUSY;
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] PC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PC_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en && (stall_cnt_r != PC_MAX)) begin
        stall_cnt_r <= stall_cnt_r + PC_ONE;
      end
      if (br_taken_E && (flush_cnt_r != PC_MAX)) begin
        flush_cnt_r <= flush_cnt_r + PC_ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl. It drives two instances
// with shared inputs: MD_LAT=4 (dut0) and MD_LAT=1 (dut1). Control outputs
// are packed as {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
// ex_mem_bubble, md_busy}.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] C_RST = 7'b0000000;
  localparam logic [6:0] C_NRM = 7'b1101000;
  localparam logic [6:0] C_LU  = 7'b0001100;
  localparam logic [6:0] C_BR  = 7'b1111100;
  localparam logic [6:0] C_BRB = 7'b1111101;
  localparam logic [6:0] C_MDI = 7'b0000010;
  localparam logic [6:0] C_MDB = 7'b0000011;
  localparam logic [6:0] C_REL = 7'b1101001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_D, rs2_D, rd_E;
  logic       rs1_used_D, rs2_used_D, mem_read_E, md_op_E, br_taken_E;

  logic        pc_en0, if_id_en0, if_id_flush0, id_ex_en0, id_ex_flush0, bub0, busy0;
  logic        pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, bub1, busy1;
  logic [31:0] stall0, flush0, stall1, flush1;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_s0 = 0, exp_f0 = 0, exp_s1 = 0, exp_f1 = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E),
    .mem_read_E(mem_read_E), .md_op_E(md_op_E), .br_taken_E(br_taken_E),
    .pc_en(pc_en0), .if_id_en(if_id_en0), .if_id_flush(if_id_flush0),
    .id_ex_en(id_ex_en0), .id_ex_flush(id_ex_flush0), .ex_mem_bubble(bub0),
    .md_busy(busy0), .stall_cnt(stall0), .flush_cnt(flush0)
  );

  pipeline_hazard_ctrl #(.MD_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E),
    .mem_read_E(mem_read_E), .md_op_E(md_op_E), .br_taken_E(br_taken_E),
    .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_flush(if_id_flush1),
    .id_ex_en(id_ex_en1), .id_ex_flush(id_ex_flush1), .ex_mem_bubble(bub1),
    .md_busy(busy1), .stall_cnt(stall1), .flush_cnt(flush1)
  );

  // Single comparison point: count it, report a miscompare.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef PERF_CNT_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  task automatic set_in(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic md, input logic br);
    rs1_D = r1; rs1_used_D = u1; rs2_D = r2; rs2_used_D = u2;
    rd_E = rd; mem_read_E = mr; md_op_E = md; br_taken_E = br;
  endtask

  // Check one cycle, then clock it. The expected counters advance by the
  // stall/branch events of this cycle.
  task automatic vec(input string tag, input logic [6:0] e0, input logic [6:0] e1);
    #1;
    if (!rst_n) begin
      exp_s0 = 0; exp_f0 = 0; exp_s1 = 0; exp_f1 = 0;
    end
    chk({tag, ".ctl0"}, {25'd0, pc_en0, if_id_en0, if_id_flush0, id_ex_en0, id_ex_flush0, bub0, busy0}, {25'd0, e0});
    chk({tag, ".ctl1"}, {25'd0, pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, bub1, busy1}, {25'd0, e1});
    chk({tag, ".stall0"}, stall0, cnt_exp(exp_s0));
    chk({tag, ".flush0"}, flush0, cnt_exp(exp_f0));
    chk({tag, ".stall1"}, stall1, cnt_exp(exp_s1));
    chk({tag, ".flush1"}, flush1, cnt_exp(exp_f1));
    if (rst_n) begin
      if (!e0[6]) exp_s0++;
      if (!e1[6]) exp_s1++;
      if (br_taken_E) begin
        exp_f0++;
        exp_f1++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    vec("rst", C_RST, C_RST);
    vec("rst_hold", C_RST, C_RST);
    rst_n = 1'b1;
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    vec("idle", C_NRM, C_NRM);

    // Load-use and its non-hazard corner cases.
    set_in(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); vec("lu_rs2", C_LU, C_LU);
    set_in(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); vec("lu_clear", C_NRM, C_NRM);
    set_in(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); vec("lu_rs1", C_LU, C_LU);
    set_in(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); vec("x0", C_NRM, C_NRM);
    set_in(5'd9, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); vec("rs1_unused", C_NRM, C_NRM);
    set_in(5'd1, 1'b1, 5'd4, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); vec("rs2_unused", C_NRM, C_NRM);

    // MUL/DIV held: 3 stalls + release, then back-to-back op.
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    vec("md1_c1", C_MDI, C_NRM);
    vec("md1_c2", C_MDB, C_NRM);
    vec("md1_c3", C_MDB, C_NRM);
    vec("md1_rel", C_REL, C_NRM);
    vec("md2_c1", C_MDI, C_NRM);
    set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    vec("md2_c2_lumask", C_MDB, C_LU);
    vec("md2_c3_lumask", C_MDB, C_LU);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    vec("md2_rel", C_REL, C_NRM);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    vec("md_done", C_NRM, C_NRM);

    // Branch beats load-use.
    set_in(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1); vec("br_lu", C_BR, C_BR);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); vec("post_br", C_NRM, C_NRM);

    // Branch while BUSY aborts to IDLE.
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); vec("md3_c1", C_MDI, C_NRM);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); vec("br_busy", C_BRB, C_BR);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); vec("br_busy_after", C_NRM, C_NRM);

    // Branch together with md op from IDLE: FSM stays IDLE.
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); vec("br_md_idle", C_BR, C_BR);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); vec("br_md_after", C_NRM, C_NRM);

    // Reset at cnt=1, then a full fresh sequence.
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    vec("md4_c1", C_MDI, C_NRM);
    vec("md4_c2", C_MDB, C_NRM);
    rst_n = 1'b0;
    vec("rst_busy", C_RST, C_RST);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    vec("rst_busy_hold", C_RST, C_RST);
    rst_n = 1'b1;
    vec("rst_rel", C_NRM, C_NRM);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    vec("md5_c1", C_MDI, C_NRM);
    vec("md5_c2", C_MDB, C_NRM);
    vec("md5_c3", C_MDB, C_NRM);
    vec("md5_rel", C_REL, C_NRM);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    vec("final", C_NRM, C_NRM);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard controller for the 5-stage in-order pipeline. It produces the PC enable, the IF/ID and ID/EX enable and flush controls, and the EX/MEM bubble control. It resolves three conditions: load-use data hazards, taken-branch redirects from EX, and multi-cycle MUL/DIV occupancy of EX through an internal state machine. Its outputs feed the stage registers directly in the same cycle, so hazard decode is combinational from current inputs and FSM state.

## Interface
- MD_LAT, 4: total cycles a MUL/DIV op occupies EX (≥1)
- CNT_W, 32: width of performance counters
- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  async active-low reset
- rs1_D, rs2_D  in  5  source registers of the instruction in ID
- rs1_used_D, rs2_used_D  in  1  source actually read by the ID instruction
- rd_E  in  5  destination register of the instruction in EX
- mem_read_E  in  1  EX instruction is a load
- md_op_E  in  1  EX instruction is MUL/DIV
- br_taken_E  in  1  EX resolved a taken branch/jump (PC redirect)
- pc_en  out  1  PC register update enable
- if_id_en, if_id_flush  out  1  IF/ID register enable / flush
- id_ex_en, id_ex_flush  out  1  ID/EX register enable / flush (bubble)
- ex_mem_bubble  out  1  load NOP into EX/MEM this cycle
- md_busy  out  1  FSM in BUSY
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- load_use = mem_read_E & (rd_E≠0) & ((rs1_used_D & rs1_D==rd_E) | (rs2_used_D & rs2_D==rd_E)).
- md_stall = (state==IDLE & md_op_E & MD_LAT≥2) | (state==BUSY & cnt≠0).
- Priority, highest first:
  - br_taken_E: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1, ex_mem_bubble=0; FSM forced to IDLE, cnt=0.
  - md_stall: pc_en=0, if_id_en=0, id_ex_en=0, all flushes 0, ex_mem_bubble=1.
  - load_use: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, if_id_flush=0, ex_mem_bubble=0.
  - Otherwise: all enables 1, all flushes 0, ex_mem_bubble=0.
- FSM, states IDLE and BUSY; cnt is ⌈log2(MD_LAT)⌉ bits, min 1:
  - IDLE & md_op_E & MD_LAT≥2 & !br_taken_E → BUSY, cnt ← MD_LAT−2.
  - BUSY & cnt≠0 → BUSY, cnt ← cnt−1.
  - BUSY & cnt==0 → IDLE. This is the release cycle: no md stall, and md_op_E is ignored.
  - MD_LAT==1: FSM never leaves IDLE and md_stall is 0.
- Result: a MUL/DIV op occupies EX for exactly MD_LAT cycles, with MD_LAT−1 stall cycles.
- md_busy = (state==BUSY).
- load_use evaluated during md_stall is masked. The stalled ID instruction is re-checked after release.

## Timing
- Control outputs are combinational from inputs, state and cnt, with zero-cycle latency. State and counters update on posedge clk.
- While rst_n=0: pc_en=if_id_en=id_ex_en=0, all flushes 0, ex_mem_bubble=0, md_busy=0, state=IDLE, cnt=0, stall_cnt=flush_cnt=0.
- Reset assertion mid-BUSY aborts the op. After release, FSM starts in IDLE, and a md_op_E present then restarts a full MD_LAT sequence.
- Load-use costs exactly 1 stall cycle. Next cycle, rd_E is a bubble (mem_read_E=0), so the hazard clears.
- Simultaneous br_taken_E with load_use: branch wins and no stall is applied, because the ID instruction is flushed.
- Simultaneous br_taken_E with md_op_E is not legal (same EX slot). If it occurs, branch wins and the FSM goes to IDLE.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments on each clocked cycle with rst_n=1 and pc_en=0.
  - flush_cnt increments on each cycle with br_taken_E=1.
  - Both counters saturate at 2^CNT_W−1.
- PERF_CNT_EN undefined: counter logic is removed, and stall_cnt and flush_cnt are tied to 0. All other behaviour is identical.

## Test plan
- Load-use: mem_read_E=1, rd_E=5, rs2_D=5, rs2_used_D=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (mem_read_E=0) all enables 1.
- x0 and unused source: rd_E=0 with rs1_D=0, or rs1_D==rd_E with rs1_used_D=0 → no stall.
- MUL/DIV with MD_LAT=4: md_op_E held → pc_en=0 and ex_mem_bubble=1 for exactly 3 cycles, md_busy=1 for cycles 2–4, release on cycle 4; back-to-back md op next cycle → another 3-cycle stall.
- Branch over load-use: br_taken_E=1 together with a load-use match → if_id_flush=id_ex_flush=1, pc_en=1; flush_cnt +1; stall_cnt unchanged.
- Reset mid-BUSY: assert rst_n=0 at cnt=1 → all enables 0 immediately; after release with md_op_E=0 → IDLE, outputs normal, counters 0.
- MD_LAT=1 build plus PERF_CNT_EN on/off: md_op_E → no stall ever; with the macro, stall_cnt equals the number of observed pc_en=0 cycles; without it, both counters read 0.
